// File: rtl/vend_fsm.sv
// Vending-machine controller: accumulates coin credit, dispenses at PRICE, returns change pulses.
// Optional inactivity refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_fsm #(
  parameter int NUM_COINS   = 3,
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_COINS-1:0] coin,
  input  logic                 cancel,
  output logic                 dispense,
  output logic                 change,
  output logic                 busy,
  output logic [CREDIT_W-1:0]  credit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  generate
    if (PRICE < 1 || TIMEOUT_CYC < 1 ||
        longint'(PRICE + NUM_COINS - 1) >= (longint'(1) << CREDIT_W)) begin : g_param_check
      $error("vend_fsm: PRICE/TIMEOUT_CYC must be >= 1 and CREDIT_W must hold PRICE+NUM_COINS-1");
    end
  endgenerate

  state_t                state_reg, state_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [NUM_COINS-1:0]  coin_q;
  logic [NUM_COINS-1:0]  coin_rise;
  logic                  coin_hit;
  logic [CREDIT_W-1:0]   coin_value;
  logic [CREDIT_W-1:0]   coin_sum;
  logic                  timeout;

  assign coin_rise = coin & ~coin_q;
  assign coin_sum  = credit_reg + coin_value;

  // Scan from the top down so the lowest-index edge is the one that survives.
  always_comb begin
    coin_hit   = 1'b0;
    coin_value = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (coin_rise[i]) begin
        coin_hit   = 1'b1;
        coin_value = CREDIT_W'(i + 1);
      end
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

  assign timeout = (idle_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_cnt_next = '0;
    if (state_reg == COLLECT && !cancel && !coin_hit && !timeout) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    case (state_reg)
      IDLE: begin
        if (coin_hit) begin
          credit_next = coin_sum;
          state_next  = (coin_sum >= PRICE_C) ? DISPENSE : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_next = CHANGE;
        end else if (coin_hit) begin
          credit_next = coin_sum;
          state_next  = (coin_sum >= PRICE_C) ? DISPENSE : COLLECT;
        end else if (timeout) begin
          state_next = CHANGE;
        end
      end
      DISPENSE: begin
        credit_next = credit_reg - PRICE_C;
        state_next  = (credit_reg == PRICE_C) ? IDLE : CHANGE;
      end
      CHANGE: begin
        credit_next = credit_reg - ONE_C;
        if (credit_reg == ONE_C) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
  end

  // coin_q tracks the buttons even in reset so a held button never fires afterwards.
  always_ff @(posedge clk) begin
    coin_q <= coin;
    if (reset) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
    end
  end

  assign dispense = (state_reg == DISPENSE);
  assign change   = (state_reg == CHANGE);
  assign busy     = (state_reg == DISPENSE) || (state_reg == CHANGE);
  assign credit   = credit_reg;

endmodule

// File: tb/tb_vend_fsm.sv
// Self-checking bench for vend_fsm: directed scenarios plus randomized traffic against
// a pulse-queue reference model of the vending rules.
module tb_vend_fsm;

  localparam int NC = 3;
  localparam int PR = 3;
  localparam int CW = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cancel = 1'b0;
  logic [NC-1:0] coin = '0;
  logic          dispense, change, busy;
  logic [CW-1:0] credit;

  vend_fsm #(
    .NUM_COINS(NC), .PRICE(PR), .CREDIT_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .reset(reset), .coin(coin), .cancel(cancel),
    .dispense(dispense), .change(change), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending busy-period outputs are a queue of pulses.
  typedef struct {
    bit d;
    bit c;
    int cr;
  } out_t;

  out_t          pend[$];
  int            m_credit = 0;
  logic [NC-1:0] m_prev = '0;
  int            m_idle = 0;
  logic [CW+2:0] exp_vec = '0;
  logic [CW+2:0] dut_vec;
  int            n_d, n_c;

  assign dut_vec = {dispense, change, busy, credit};

  function automatic void push_refund(input int amount);
    for (int cr = amount; cr >= 1; cr--) pend.push_back('{1'b0, 1'b1, cr});
  endfunction

  function automatic void model_step();
    logic [NC-1:0] rise;
    int k;
    if (reset) begin
      pend.delete();
      m_credit = 0;
      m_prev   = coin;
      m_idle   = 0;
    end else begin
      rise   = coin & ~m_prev;
      m_prev = coin;
      if (pend.size() > 0) begin
        pend.delete(0);
        if (pend.size() == 0) m_credit = 0;
        m_idle = 0;
      end else if (m_credit > 0 && cancel) begin
        push_refund(m_credit);
        m_idle = 0;
      end else if (rise != '0) begin
        k = 0;
        for (int i = NC - 1; i >= 0; i--) if (rise[i]) k = i;
        m_credit += k + 1;
        m_idle = 0;
        if (m_credit >= PR) begin
          pend.push_back('{1'b1, 1'b0, m_credit});
          push_refund(m_credit - PR);
        end
      end else if (m_credit > 0) begin
`ifdef VEND_TIMEOUT_EN
        m_idle++;
        if (m_idle == TO) begin
          m_idle = 0;
          push_refund(m_credit);
        end
`endif
      end
    end
    if (pend.size() > 0) exp_vec = {pend[0].d, pend[0].c, 1'b1, CW'(pend[0].cr)};
    else                 exp_vec = {1'b0, 1'b0, 1'b0, CW'(m_credit)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    n_d += int'(dispense);
    n_c += int'(change);
  endtask

  // Returns the machine to IDLE: refund any credit, let pulses drain.
  task automatic settle();
    coin   = '0;
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    coin  = 3'b001;
    repeat (2) step();
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_values got %h want 0", dut_vec);
    end
    checks++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_held_coin cyc %0d got %h want %h", i, dut_vec, exp_vec);
      end
      checks++;
    end
    coin = '0;
    step();
    $display("txn reset held_coin credit=%0d", credit);
  endtask

  task automatic run_seq(input string name, input logic [NC-1:0] cs[], input logic ks[]);
    n_d = 0;
    n_c = 0;
    for (int i = 0; i < cs.size(); i++) begin
      coin   = cs[i];
      cancel = ks[i];
      step();
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s cyc %0d got %h want %h", name, i, dut_vec, exp_vec);
      end
      checks++;
    end
    coin   = '0;
    cancel = 1'b0;
  endtask

  task automatic test_single_coins();
    logic [NC-1:0] cs[] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
    logic          ks[] = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_seq("single_coins", cs, ks);
    if (n_d !== 1 || n_c !== 0 || dut_vec !== '0) begin
      errors++;
      $display("FAIL single_coins_summary got d=%0d c=%0d vec=%h want d=1 c=0 vec=0", n_d, n_c, dut_vec);
    end
    checks++;
    $display("txn single_coins dispense=%0d change=%0d credit=%0d", n_d, n_c, credit);
  endtask

  task automatic test_change();
    logic [NC-1:0] cs[] = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic          ks[] = '{0, 0, 0, 0, 0, 0, 0};
    run_seq("change", cs, ks);
    if (n_d !== 1 || n_c !== 2 || credit !== '0) begin
      errors++;
      $display("FAIL change_summary got d=%0d c=%0d credit=%0d want d=1 c=2 credit=0", n_d, n_c, credit);
    end
    checks++;
    $display("txn change dispense=%0d change=%0d credit=%0d", n_d, n_c, credit);
  endtask

  task automatic test_cancel();
    logic [NC-1:0] cs[] = '{3'b010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic          ks[] = '{0, 0, 1, 0, 0, 0, 0};
    run_seq("cancel", cs, ks);
    if (n_d !== 0 || n_c !== 2 || busy !== 1'b0 || credit !== '0) begin
      errors++;
      $display("FAIL cancel_summary got d=%0d c=%0d busy=%b credit=%0d want d=0 c=2 busy=0 credit=0",
               n_d, n_c, busy, credit);
    end
    checks++;
    $display("txn cancel dispense=%0d change=%0d credit=%0d", n_d, n_c, credit);
  endtask

  task automatic test_held();
    coin = 3'b001;
    repeat (10) step();
    coin = '0;
    step();
    if (credit !== CW'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_coin got credit=%0d busy=%b want credit=1 busy=0", credit, busy);
    end
    checks++;
    $display("txn held_coin credit=%0d", credit);
    settle();
  endtask

  task automatic test_simultaneous();
    coin = 3'b101;
    step();
    coin = '0;
    step();
    if (credit !== CW'(1)) begin
      errors++;
      $display("FAIL simultaneous got credit=%0d want 1", credit);
    end
    checks++;
    $display("txn simultaneous credit=%0d", credit);
    settle();
  endtask

  task automatic test_reset_mid();
    int guard;
    coin = 3'b010; step();
    coin = 3'b000; step();
    coin = 3'b100; step();
    coin = 3'b000;
    guard = 0;
    while (change !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    if (change !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait got change=%b want 1 within 10 cycles", change);
    end
    checks++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h want 0", dut_vec);
    end
    checks++;
    n_c = 0;
    repeat (5) step();
    if (n_c !== 0 || credit !== '0) begin
      errors++;
      $display("FAIL reset_mid_after got change_pulses=%0d credit=%0d want 0 0", n_c, credit);
    end
    checks++;
    $display("txn reset_mid change_after=%0d", n_c);
  endtask

  task automatic test_timeout();
    int mism = 0;
    n_c = 0;
    coin = 3'b001; step();
    coin = '0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dut_vec !== exp_vec) mism++;
    end
`ifdef VEND_TIMEOUT_EN
    if (mism != 0 || n_c !== 1 || credit !== '0) begin
      errors++;
      $display("FAIL timeout got mism=%0d change=%0d credit=%0d want 0 1 0", mism, n_c, credit);
    end
`else
    if (mism != 0 || n_c !== 0 || credit !== CW'(1)) begin
      errors++;
      $display("FAIL no_timeout got mism=%0d change=%0d credit=%0d want 0 0 1", mism, n_c, credit);
    end
`endif
    checks++;
    $display("txn timeout change=%0d credit=%0d", n_c, credit);
    settle();
  endtask

  task automatic test_random();
    int mism = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) coin = NC'($urandom_range(0, (1 << NC) - 1));
      cancel = ($urandom_range(0, 15) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      step();
      if (dut_vec !== exp_vec) begin
        errors++;
        mism++;
        if (mism <= 10)
          $display("FAIL random cyc %0d got %h want %h", i, dut_vec, exp_vec);
      end
      checks++;
    end
    coin   = '0;
    cancel = 1'b0;
    reset  = 1'b0;
    $display("txn random cycles=4000 mismatches=%0d", mism);
  endtask

  initial begin
    test_reset();
    test_single_coins();
    test_change();
    test_cancel();
    test_held();
    test_simultaneous();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
